// File: rtl/control_pkg.sv
// rtl/control_pkg.sv - opcodes, IR field positions and state encoding for control_sequencer
package control_pkg;

  localparam int OPCODE_W = 5;
  localparam int REG_W    = 4;

  localparam logic [OPCODE_W-1:0] OP_ADD = 5'b00011;
  localparam logic [OPCODE_W-1:0] OP_SUB = 5'b00100;
  localparam logic [OPCODE_W-1:0] OP_AND = 5'b00101;
  localparam logic [OPCODE_W-1:0] OP_OR  = 5'b00110;

  localparam int OP_HI = 31;
  localparam int RA_HI = 26;
  localparam int RB_HI = 22;
  localparam int RC_HI = 18;

  typedef enum logic [3:0] {
    S_RESET = 4'h0,
    S_T0    = 4'h1,
    S_T1    = 4'h2,
    S_T1W   = 4'h3,
    S_T2    = 4'h4,
    S_T3    = 4'h5,
    S_T4    = 4'h6,
    S_T5    = 4'h7,
    S_HALT  = 4'hF
  } state_e;

  function automatic logic op_legal(input logic [OPCODE_W-1:0] op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) || (op == OP_OR);
  endfunction

endpackage

// File: rtl/reg_select.sv
// rtl/reg_select.sv - picks Ra/Rb/Rc and expands it to one-hot register load/drive enables
module reg_select
  import control_pkg::*;
#(
  parameter int NREG = 16
) (
  input  logic [REG_W-1:0] ra,
  input  logic [REG_W-1:0] rb,
  input  logic [REG_W-1:0] rc,
  input  logic             gra,
  input  logic             grb,
  input  logic             grc,
  input  logic             rin_en,
  input  logic             rout_en,
  output logic [NREG-1:0]  Rin,
  output logic [NREG-1:0]  Rout
);

  logic [REG_W-1:0] sel;
  logic [NREG-1:0]  onehot;

  always_comb begin
    sel = '0;
    if (gra)      sel = ra;
    else if (grb) sel = rb;
    else if (grc) sel = rc;
    onehot = {{(NREG-1){1'b0}}, 1'b1} << sel;
    Rin    = rin_en  ? onehot : '0;
    Rout   = rout_en ? onehot : '0;
  end

endmodule

// File: rtl/control_sequencer.sv
// rtl/control_sequencer.sv - hardwired fetch/execute sequencer for three-register ALU ops
module control_sequencer
  import control_pkg::*;
#(
  parameter int OPW  = 5,
  parameter int NREG = 16
) (
  input  logic            Clock,
  input  logic            Reset,
  input  logic [31:0]     IR,
  input  logic            Mem_ready,
  output logic            PCout,
  output logic            Zlowout,
  output logic            MDRout,
  output logic            MARin,
  output logic            Zin,
  output logic            PCin,
  output logic            MDRin,
  output logic            IRin,
  output logic            Yin,
  output logic            IncPC,
  output logic            Read,
  output logic            ADD,
  output logic            SUB,
  output logic            AND,
  output logic            OR,
  output logic [NREG-1:0] Rin,
  output logic [NREG-1:0] Rout,
  output logic            Halted
);

  state_e state, state_next;

  logic [OPW-1:0]   opcode;
  logic [REG_W-1:0] ra, rb, rc;
  logic             gra, grb, grc, rin_en, rout_en;
  logic             unused_ir;

  assign opcode    = IR[OP_HI -: OPW];
  assign ra        = IR[RA_HI -: REG_W];
  assign rb        = IR[RB_HI -: REG_W];
  assign rc        = IR[RC_HI -: REG_W];
  assign unused_ir = ^IR[14:0];

  always_ff @(posedge Clock) begin
    if (Reset) state <= S_RESET;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_RESET:    state_next = S_T0;
      S_T0:       state_next = S_T1;
      S_T1, S_T1W: state_next = Mem_ready ? S_T2 : S_T1W;
      S_T2:       state_next = S_T3;
      S_T3:       state_next = op_legal(opcode) ? S_T4 : S_HALT;
      S_T4:       state_next = S_T5;
      S_T5:       state_next = S_T0;
      S_HALT:     state_next = S_HALT;
      default:    state_next = S_RESET;
    endcase
  end

  always_comb begin
    PCout = 1'b0; Zlowout = 1'b0; MDRout = 1'b0; MARin = 1'b0;
    Zin = 1'b0; PCin = 1'b0; MDRin = 1'b0; IRin = 1'b0; Yin = 1'b0;
    IncPC = 1'b0; Read = 1'b0; ADD = 1'b0; SUB = 1'b0; AND = 1'b0; OR = 1'b0;
    Halted = 1'b0;
    gra = 1'b0; grb = 1'b0; grc = 1'b0; rin_en = 1'b0; rout_en = 1'b0;
    case (state)
      S_T0: begin PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; Zin = 1'b1; end
      S_T1: begin Zlowout = 1'b1; PCin = 1'b1; Read = 1'b1; MDRin = 1'b1; end
      // Wait state keeps the read alive but must not reload PC a second time
      S_T1W: begin Read = 1'b1; MDRin = 1'b1; end
      S_T2: begin MDRout = 1'b1; IRin = 1'b1; end
      S_T3: begin grb = 1'b1; rout_en = 1'b1; Yin = 1'b1; end
      S_T4: begin
        grc = 1'b1; rout_en = 1'b1; Zin = 1'b1;
        case (opcode)
          OP_ADD:  ADD = 1'b1;
          OP_SUB:  SUB = 1'b1;
          OP_AND:  AND = 1'b1;
          OP_OR:   OR  = 1'b1;
          default: ;
        endcase
      end
      S_T5: begin gra = 1'b1; rin_en = 1'b1; Zlowout = 1'b1; end
      S_HALT: Halted = 1'b1;
      default: ;
    endcase
  end

  reg_select #(.NREG(NREG)) u_reg_select (
    .ra      (ra),
    .rb      (rb),
    .rc      (rc),
    .gra     (gra),
    .grb     (grb),
    .grc     (grc),
    .rin_en  (rin_en),
    .rout_en (rout_en),
    .Rin     (Rin),
    .Rout    (Rout)
  );

endmodule

// File: tb/tb_control_sequencer.sv
// tb/tb_control_sequencer.sv - directed scoreboard bench for control_sequencer
module tb_control_sequencer;

  logic        Clock = 1'b0;
  logic        Reset;
  logic [31:0] IR;
  logic        Mem_ready;
  logic PCout, Zlowout, MDRout, MARin, Zin, PCin, MDRin, IRin, Yin, IncPC, Read;
  logic ADD, SUB, AND, OR, Halted;
  logic [15:0] Rin, Rout;

  typedef enum int {P_RST, P_T0, P_T1, P_T1W, P_T2, P_T3, P_T4, P_T5, P_HALT} ph_e;

  typedef struct packed {
    logic pcout, zlowout, mdrout, marin, zin, pcin, mdrin, irin, yin, incpc, read;
    logic add, sub, and_op, or_op, halted;
    logic [15:0] rin, rout;
  } obs_t;

  obs_t obs_w;
  obs_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   rin_pulses = 0;
  int   snap;

  always #5 Clock = ~Clock;

  control_sequencer #(.OPW(5), .NREG(16)) dut (
    .Clock(Clock), .Reset(Reset), .IR(IR), .Mem_ready(Mem_ready),
    .PCout(PCout), .Zlowout(Zlowout), .MDRout(MDRout), .MARin(MARin),
    .Zin(Zin), .PCin(PCin), .MDRin(MDRin), .IRin(IRin), .Yin(Yin),
    .IncPC(IncPC), .Read(Read), .ADD(ADD), .SUB(SUB), .AND(AND), .OR(OR),
    .Rin(Rin), .Rout(Rout), .Halted(Halted)
  );

  assign obs_w = {PCout, Zlowout, MDRout, MARin, Zin, PCin, MDRin, IRin, Yin, IncPC, Read,
                  ADD, SUB, AND, OR, Halted, Rin, Rout};

  function automatic logic [31:0] mk(input logic [4:0] op, input logic [3:0] ra,
                                     input logic [3:0] rb, input logic [3:0] rc);
    return {op, ra, rb, rc, 15'h0};
  endfunction

  // Reference strobe table for one T-step given the instruction in IR
  function automatic obs_t ev(input ph_e ph, input logic [31:0] ir);
    obs_t o;
    o = '0;
    case (ph)
      P_T0:  begin o.pcout = 1; o.marin = 1; o.incpc = 1; o.zin = 1; end
      P_T1:  begin o.zlowout = 1; o.pcin = 1; o.read = 1; o.mdrin = 1; end
      P_T1W: begin o.read = 1; o.mdrin = 1; end
      P_T2:  begin o.mdrout = 1; o.irin = 1; end
      P_T3:  begin o.rout = 16'h1 << ir[22:19]; o.yin = 1; end
      P_T4:  begin
        o.rout   = 16'h1 << ir[18:15];
        o.zin    = 1;
        o.add    = (ir[31:27] == 5'b00011);
        o.sub    = (ir[31:27] == 5'b00100);
        o.and_op = (ir[31:27] == 5'b00101);
        o.or_op  = (ir[31:27] == 5'b00110);
      end
      P_T5:  begin o.zlowout = 1; o.rin = 16'h1 << ir[26:23]; end
      P_HALT: o.halted = 1;
      default: ;
    endcase
    return o;
  endfunction

  task automatic tick(input ph_e ph);
    obs_t exp;
    sb.push_back(ev(ph, IR));
    @(negedge Clock);
    exp = sb.pop_front();
    checks++;
    assert (obs_w === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", ph.name(), obs_w, exp);
    end
    checks++;
    assert ($countones(Rin) <= 1 && $countones(Rout) <= 1) else begin
      errors++;
      $error("FAIL onehot: observed Rin=%h Rout=%h expected at most one bit each", Rin, Rout);
    end
    checks++;
    assert (!((|Rin) && (|Rout))) else begin
      errors++;
      $error("FAIL overlap: observed Rin=%h Rout=%h expected not both nonzero", Rin, Rout);
    end
    if (|Rin) rin_pulses++;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  logic [31:0] prog [4];

  initial begin
    Reset = 1'b1;
    Mem_ready = 1'b1;
    IR = 32'h20228000;
    tick(P_RST);
    tick(P_RST);
    Reset = 1'b0;

    // sub R0,R4,R5 with zero-wait memory
    tick(P_T0); tick(P_T1); tick(P_T2);
    tick(P_T3); chk("t3_rout", {16'h0, Rout}, 32'h0010); chk("t3_yin", {31'h0, Yin}, 32'h1);
    tick(P_T4); chk("t4_rout", {16'h0, Rout}, 32'h0020); chk("t4_sub", {31'h0, SUB}, 32'h1);
    tick(P_T5); chk("t5_rin", {16'h0, Rin}, 32'h0001);
    tick(P_T0);

    // and R0,R4,R5
    IR = 32'h28228000;
    tick(P_T1); tick(P_T2); tick(P_T3);
    tick(P_T4); chk("t4_and", {31'h0, AND}, 32'h1);
    tick(P_T5); tick(P_T0);

    // memory holds off three sampled cycles
    IR = mk(5'b00011, 4'd9, 4'd2, 4'd11);
    tick(P_T1); Mem_ready = 1'b0;
    tick(P_T1W); tick(P_T1W); tick(P_T1W); Mem_ready = 1'b1;
    tick(P_T2); tick(P_T3); tick(P_T4); tick(P_T5); tick(P_T0);

    // illegal opcode traps until reset
    IR = 32'hF8000000;
    tick(P_T1); tick(P_T2); tick(P_T3);
    for (int i = 0; i < 20; i++) tick(P_HALT);
    Reset = 1'b1;
    tick(P_RST);
    Reset = 1'b0;
    tick(P_T0);

    // reset while in T4 aborts the write-back
    IR = mk(5'b00110, 4'd2, 4'd3, 4'd4);
    snap = rin_pulses;
    tick(P_T1); tick(P_T2); tick(P_T3); tick(P_T4);
    Reset = 1'b1;
    tick(P_RST);
    Reset = 1'b0;
    chk("abort_rin", rin_pulses - snap, 0);

    // four back-to-back instructions, including Ra==Rb==Rc
    prog[0] = mk(5'b00011, 4'd3, 4'd1, 4'd2);
    prog[1] = mk(5'b00100, 4'd15, 4'd15, 4'd15);
    prog[2] = mk(5'b00101, 4'd7, 4'd0, 4'd9);
    prog[3] = mk(5'b00110, 4'd0, 4'd14, 4'd6);
    snap = rin_pulses;
    for (int i = 0; i < 4; i++) begin
      IR = prog[i];
      tick(P_T0); tick(P_T1); tick(P_T2); tick(P_T3); tick(P_T4); tick(P_T5);
    end
    chk("b2b_rin_pulses", rin_pulses - snap, 4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
